// File: rtl/rc4_pkg.sv
// Shared RC4 definitions: key-scheduling FSM states, table constants and
// the key-byte selector used by the swap pass.
package rc4_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_SI,
      WAIT_SI,
      RD_SJ,
      WAIT_SJ,
      WR_SI,
      WR_SJ,
      DONE
   } state_t;

   localparam int S_SIZE            = 256;
   localparam int DEFAULT_KEY_BYTES = 3;
   localparam int MAX_KEY_BYTES     = 32;

   // Byte 0 of the key is its most significant byte.
   function automatic logic [7:0] key_byte(input logic [8*MAX_KEY_BYTES-1:0] key,
                                           input int key_bytes,
                                           input int idx);
      logic [8*MAX_KEY_BYTES-1:0] shifted;
      shifted = key >> (8 * (key_bytes - 1 - idx));
      return shifted[7:0];
   endfunction

endpackage

// File: rtl/ksa_swap.sv
// RC4 key-scheduling swap pass over a 256-byte S memory with 1-cycle read latency.
// Six cycles per index; memory port outputs are registered from the next-state decode.
module ksa_swap
   import rc4_pkg::*;
#(
   parameter int KEY_BYTES = DEFAULT_KEY_BYTES
) (
   input  logic                   CLOCK_50,
   input  logic                   reset,
   input  logic                   start,
   input  logic [8*KEY_BYTES-1:0] secret_key,
   output logic [7:0]             mem_address,
   output logic [7:0]             mem_data,
   output logic                   mem_wren,
   input  logic [7:0]             mem_q,
   output logic                   busy,
   output logic                   done
);

   localparam logic [7:0] I_LAST    = 8'(S_SIZE - 1);
   localparam logic [7:0] KIDX_LAST = 8'(KEY_BYTES - 1);

   state_t     state_q, state_d;
   logic [7:0] i_q, i_d;
   logic [7:0] j_q, j_d;
   logic [7:0] si_q, si_d;
   logic [7:0] sj_q, sj_d;
   logic [7:0] kidx_q, kidx_d;
   logic [7:0] mem_address_q, mem_address_d;
   logic [7:0] mem_data_q, mem_data_d;
   logic       mem_wren_q, mem_wren_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   logic [8*MAX_KEY_BYTES-1:0] key_ext;
   assign key_ext = (8*MAX_KEY_BYTES)'(secret_key);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      si_d    = si_q;
      sj_d    = sj_q;
      kidx_d  = kidx_q;

      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RD_SI;
               i_d     = 8'd0;
               j_d     = 8'd0;
               kidx_d  = 8'd0;
            end
         end
         RD_SI:   state_d = WAIT_SI;
         WAIT_SI: begin
            si_d    = mem_q;
            j_d     = j_q + mem_q + key_byte(key_ext, KEY_BYTES, int'(kidx_q));
            state_d = RD_SJ;
         end
         RD_SJ:   state_d = WAIT_SJ;
         WAIT_SJ: begin
            sj_d    = mem_q;
            state_d = WR_SI;
         end
         WR_SI:   state_d = WR_SJ;
         WR_SJ: begin
            if (i_q == I_LAST) begin
               state_d = DONE;
            end else begin
               i_d     = i_q + 8'd1;
               kidx_d  = (kidx_q == KIDX_LAST) ? 8'd0 : kidx_q + 8'd1;
               state_d = RD_SI;
            end
         end
         default: state_d = IDLE;
      endcase

      // Decoding the next state lets the port flops present each state's
      // address/data during that state, so reads land in the WAIT states.
      mem_address_d = 8'd0;
      mem_data_d    = 8'd0;
      mem_wren_d    = 1'b0;
      case (state_d)
         RD_SI:   mem_address_d = i_d;
         RD_SJ:   mem_address_d = j_d;
         WR_SI: begin
            mem_address_d = i_d;
            mem_data_d    = sj_d;
            mem_wren_d    = 1'b1;
         end
         WR_SJ: begin
            mem_address_d = j_d;
            mem_data_d    = si_d;
            mem_wren_d    = 1'b1;
         end
         default: ;
      endcase

      busy_d = (state_d != IDLE) && (state_d != DONE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         i_q           <= 8'd0;
         j_q           <= 8'd0;
         si_q          <= 8'd0;
         sj_q          <= 8'd0;
         kidx_q        <= 8'd0;
         mem_address_q <= 8'd0;
         mem_data_q    <= 8'd0;
         mem_wren_q    <= 1'b0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         i_q           <= i_d;
         j_q           <= j_d;
         si_q          <= si_d;
         sj_q          <= sj_d;
         kidx_q        <= kidx_d;
         mem_address_q <= mem_address_d;
         mem_data_q    <= mem_data_d;
         mem_wren_q    <= mem_wren_d;
         busy_q        <= busy_d;
         done_q        <= done_d;
      end
   end

   assign mem_address = mem_address_q;
   assign mem_data    = mem_data_q;
   assign mem_wren    = mem_wren_q;
   assign busy        = busy_q;
   assign done        = done_q;

endmodule

// File: tb/tb_ksa_swap.sv
// Directed bench for ksa_swap: behavioural S memory, reference KSA model,
// cycle-accurate timing, restart, start-while-busy and mid-pass reset checks.
module tb_ksa_swap;

   logic        CLOCK_50;
   logic        reset;
   logic        start;
   logic [23:0] secret_key;
   logic [7:0]  mem_address;
   logic [7:0]  mem_data;
   logic        mem_wren;
   logic [7:0]  mem_q;
   logic        busy;
   logic        done;

   logic [7:0]  mem [256];
   logic [7:0]  model_s [256];
   logic        load_id;
   int          n_checks;
   int          n_errors;

   ksa_swap #(.KEY_BYTES(3)) dut (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .start       (start),
      .secret_key  (secret_key),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q),
      .busy        (busy),
      .done        (done)
   );

   initial begin
      CLOCK_50 = 1'b0;
      forever #5 CLOCK_50 = ~CLOCK_50;
   end

   always @(posedge CLOCK_50) begin
      if (load_id) begin
         for (int a = 0; a < 256; a++) mem[a] <= 8'(a);
      end else if (mem_wren) begin
         mem[mem_address] <= mem_data;
      end
      mem_q <= mem[mem_address];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic preload_identity();
      @(negedge CLOCK_50);
      load_id = 1'b1;
      @(negedge CLOCK_50);
      load_id = 1'b0;
      for (int a = 0; a < 256; a++) model_s[a] = 8'(a);
   endtask

   task automatic model_ksa(input logic [23:0] key);
      logic [7:0] kb [3];
      logic [7:0] j;
      logic [7:0] t;
      kb[0] = key[23:16];
      kb[1] = key[15:8];
      kb[2] = key[7:0];
      j = 8'd0;
      for (int a = 0; a < 256; a++) begin
         j = j + model_s[a] + kb[a % 3];
         t = model_s[a];
         model_s[a] = model_s[j];
         model_s[j] = t;
      end
   endtask

   task automatic compare_s(input string tag);
      int nmis;
      nmis = 0;
      for (int a = 0; a < 256; a++) if (mem[a] !== model_s[a]) nmis++;
      check(tag, nmis, 0);
   endtask

   // mode 0: key 0x000249 from identity, 1: zero key, 2: rerun from DONE.
   task automatic run_pass(input int mode, input bit glitch);
      int k;
      int done_at;
      int wr_cnt;
      int early_wr;
      done_at  = -1;
      wr_cnt   = 0;
      early_wr = 0;
      @(negedge CLOCK_50);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      check("busy_after_accept", busy, 1);
      check("done_cleared", done, 0);
      for (k = 0; k <= 1600 && done_at < 0; k++) begin
         if (mem_wren) wr_cnt++;
         if (k < 4 && mem_wren) early_wr++;
         if (mode == 0 && k == 4) begin
            check("first_wr_en", mem_wren, 1);
            check("first_wr_addr", mem_address, 8'h00);
            check("first_wr_data", mem_data, 8'h00);
         end
         if (k == 18) begin
            if (mode == 0) begin
               check("S0_after_i2", mem[0], 8'h00);
               check("S1_after_i2", mem[1], 8'h03);
               check("S3_after_i2", mem[3], 8'h01);
               check("S2_after_i2", mem[2], 8'h4E);
               check("S78_after_i2", mem[78], 8'h02);
            end else if (mode == 1) begin
               check("zk_S0", mem[0], 8'h00);
               check("zk_S1", mem[1], 8'h01);
               check("zk_S2", mem[2], 8'h03);
               check("zk_S3", mem[3], 8'h02);
            end
         end
         if (glitch && k == 99) start = 1'b1;
         if (glitch && k == 100) start = 1'b0;
         if (done) done_at = k;
         else @(negedge CLOCK_50);
      end
      check("no_early_write", early_wr, 0);
      check("done_cycle", done_at, 1536);
      check("write_count", wr_cnt, 512);
      check("busy_at_done", busy, 0);
      check("idle_wren_at_done", mem_wren, 0);
   endtask

   task automatic reset_mid_pass();
      int wr_cnt;
      wr_cnt = 0;
      @(negedge CLOCK_50);
      start = 1'b1;
      @(negedge CLOCK_50);
      start = 1'b0;
      // Iteration 10 spans edges 60..65 after the accept edge.
      repeat (63) @(negedge CLOCK_50);
      #2 reset = 1'b1;
      #1;
      check("rst_mid_wren", mem_wren, 0);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_addr", mem_address, 8'h00);
      @(negedge CLOCK_50);
      reset = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLOCK_50);
         if (mem_wren || busy) wr_cnt++;
      end
      check("no_activity_after_rst", wr_cnt, 0);
   endtask

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      reset      = 1'b1;
      start      = 1'b0;
      load_id    = 1'b0;
      secret_key = 24'h0;
      repeat (3) @(negedge CLOCK_50);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wren", mem_wren, 0);
      check("rst_addr", mem_address, 8'h00);
      check("rst_data", mem_data, 8'h00);
      reset = 1'b0;

      preload_identity();
      secret_key = 24'h000249;
      run_pass(0, 1'b0);
      model_ksa(24'h000249);
      compare_s("full_S_key249");

      run_pass(2, 1'b1);
      model_ksa(24'h000249);
      compare_s("full_S_rerun");

      preload_identity();
      secret_key = 24'h000000;
      run_pass(1, 1'b0);
      model_ksa(24'h000000);
      compare_s("full_S_zero_key");

      preload_identity();
      secret_key = 24'h000249;
      reset_mid_pass();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
